frame_stream_source: RTL and testbench

Streams one stored feature map from a synchronous-read RAM into the 3x3 stride-1 padding line-buffer controller, pixel by pixel. Pixels go in the order that controller expects: y (row within column) fastest, then x. The block generates `sof` and `input_valid` for each frame, waits for the controller's post-frame flush (`busy`) to finish, then reports `done`. It is the transmitting end of the line-buffer input interface.

---
 rtl/frame_stream_source_pkg.sv | 17 +
 rtl/frame_stream_source_if.sv | 33 +++
 rtl/frame_xy_counter.sv | 61 ++++++
 rtl/frame_stream_source.sv | 110 +++++++++++
 tb/tb_frame_stream_source.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_stream_source_pkg.sv
// Shared types and widths for the frame stream source and its counter.
package frame_stream_source_pkg;

  // Count width shared with the line-buffer controller.
  localparam int unsigned CntW = 16;
  localparam int unsigned XyW  = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSof    = 3'd1,
    StStream = 3'd2,
    StDrain  = 3'd3,
    StWaitHi = 3'd4,
    StWaitLo = 3'd5
  } state_e;

endpackage

// File: rtl/frame_stream_source_if.sv
// Line-buffer input interface plus the RAM read port of the frame stream source.
interface frame_stream_source_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
);
  import frame_stream_source_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              pause;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              sof;
  logic              input_valid;
  logic [DATA_W-1:0] pixel_data;
  logic              active;
  logic              done;
  logic [XyW-1:0]    x_cnt;
  logic [XyW-1:0]    y_cnt;

  modport master (
    input  start, base_addr, pause, busy, mem_rdata,
    output mem_rd_en, mem_addr, sof, input_valid, pixel_data, active, done, x_cnt, y_cnt
  );

  modport slave (
    output start, base_addr, pause, busy, mem_rdata,
    input  mem_rd_en, mem_addr, sof, input_valid, pixel_data, active, done, x_cnt, y_cnt
  );

endinterface

// File: rtl/frame_xy_counter.sv
// Pixel position counter: y runs fastest, then x; idx is the linear pixel index.
module frame_xy_counter
  import frame_stream_source_pkg::*;
#(
  parameter int unsigned InputY = 3,
  parameter int unsigned InputX = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [XyW-1:0]  x_o,
  output logic [XyW-1:0]  y_o,
  output logic [CntW-1:0] idx_o,
  output logic            last_o
);

  localparam int unsigned NumPix = InputY * InputX;

  logic [XyW-1:0]  x_q, x_d, y_q, y_d;
  logic [CntW-1:0] idx_q, idx_d;
  logic            y_wrap, x_wrap;

  assign y_wrap = (y_q == XyW'(InputY - 1));
  assign x_wrap = (x_q == XyW'(InputX - 1));
  assign last_o = (idx_q == CntW'(NumPix - 1));

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    idx_d = idx_q;
    if (clr_i) begin
      x_d   = '0;
      y_d   = '0;
      idx_d = '0;
    end else if (en_i) begin
      y_d   = y_wrap ? '0 : y_q + 1'b1;
      idx_d = last_o ? '0 : idx_q + 1'b1;
      if (y_wrap) begin
        x_d = x_wrap ? '0 : x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      idx_q <= idx_d;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/frame_stream_source.sv
// Streams one stored feature map from a sync-read RAM into the line-buffer controller,
// y-fast/x-slow, then waits for the controller's flush before reporting done.
module frame_stream_source
  import frame_stream_source_pkg::*;
#(
  parameter int unsigned input_y = 3,
  parameter int unsigned input_x = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  frame_stream_source_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              valid_q;
  logic              rd_en, cnt_clr, last;
  logic [CntW-1:0]   idx;
  logic [XyW-1:0]    x, y;
  logic [DATA_W-1:0] pix;

  frame_xy_counter #(
    .InputY(input_y),
    .InputX(input_x)
  ) u_xy (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (cnt_clr),
    .en_i  (rd_en),
    .x_o   (x),
    .y_o   (y),
    .idx_o (idx),
    .last_o(last)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    active_d = active_q;
    done_d   = 1'b0;
    rd_en    = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The done cycle is itself IDLE; refusing start there forces a gap between frames.
        if (bus.start && !done_q) begin
          base_d   = bus.base_addr;
          active_d = 1'b1;
          state_d  = StSof;
        end
      end
      StSof: begin
        cnt_clr = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (!bus.pause) begin
          rd_en = 1'b1;
          if (last) state_d = StDrain;
        end
      end
      StDrain:  state_d = StWaitHi;
      StWaitHi: if (bus.busy) state_d = StWaitLo;
      StWaitLo: begin
        if (!bus.busy) begin
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      active_q <= active_d;
      done_q   <= done_d;
      valid_q  <= rd_en;
    end
  end

  // RAM data lands one cycle after the read, in step with valid_q.
  assign pix             = bus.mem_rdata;
  assign bus.pixel_data  = pix;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_addr    = base_q + ADDR_W'(idx);
  assign bus.sof         = (state_q == StSof);
  assign bus.input_valid = valid_q;
  assign bus.active      = active_q;
  assign bus.done        = done_q;
  assign bus.x_cnt       = x;
  assign bus.y_cnt       = y;

endmodule

// File: tb/tb_frame_stream_source.sv
// Randomized self-checking bench: a 3x3 and a 4x5 instance share stimulus, selected by sel.
`timescale 1ns/1ps
module tb_frame_stream_source;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          sel = 1'b0, start = 1'b0, pause = 1'b0, busy = 1'b0;
  logic [AW-1:0] base_addr = '0;

  frame_stream_source_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  frame_stream_source_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  frame_stream_source #(.input_y(3), .input_x(3), .DATA_W(DW), .ADDR_W(AW)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );
  frame_stream_source #(.input_y(4), .input_x(5), .DATA_W(DW), .ADDR_W(AW)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  assign bus_a.start     = start & ~sel;
  assign bus_b.start     = start & sel;
  assign bus_a.base_addr = base_addr;
  assign bus_b.base_addr = base_addr;
  assign bus_a.pause     = pause;
  assign bus_b.pause     = pause;
  assign bus_a.busy      = busy;
  assign bus_b.busy      = busy;

  // RAM[k] = k (low byte), synchronous read.
  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return a[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rdata <= ram_val(bus_a.mem_addr);
    if (bus_b.mem_rd_en) bus_b.mem_rdata <= ram_val(bus_b.mem_addr);
  end

  logic          o_sof, o_valid, o_rd, o_active, o_done;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_pix;
  logic [7:0]    o_x, o_y;
  logic [36:0]   outs_a, outs_b;
  assign o_sof    = sel ? bus_b.sof : bus_a.sof;
  assign o_valid  = sel ? bus_b.input_valid : bus_a.input_valid;
  assign o_rd     = sel ? bus_b.mem_rd_en : bus_a.mem_rd_en;
  assign o_active = sel ? bus_b.active : bus_a.active;
  assign o_done   = sel ? bus_b.done : bus_a.done;
  assign o_addr   = sel ? bus_b.mem_addr : bus_a.mem_addr;
  assign o_pix    = sel ? bus_b.pixel_data : bus_a.pixel_data;
  assign o_x      = sel ? bus_b.x_cnt : bus_a.x_cnt;
  assign o_y      = sel ? bus_b.y_cnt : bus_a.y_cnt;
  assign outs_a = {bus_a.sof, bus_a.input_valid, bus_a.mem_rd_en, bus_a.mem_addr, bus_a.active,
                   bus_a.done, bus_a.x_cnt, bus_a.y_cnt};
  assign outs_b = {bus_b.sof, bus_b.input_valid, bus_b.mem_rd_en, bus_b.mem_addr, bus_b.active,
                   bus_b.done, bus_b.x_cnt, bus_b.y_cnt};

  int checks = 0, passes = 0;
  bit pz [0:255];
  int ny, nn, exp_last, fall_c, exp_done, overlap, act_bad;
  int exp_vc[$], sof_cyc[$], done_cyc[$], val_cyc[$], rd_x[$], rd_y[$];
  logic [DW-1:0] val_pix[$];
  logic [AW-1:0] rd_addr[$];

  task automatic clear_pause();
    for (int i = 0; i < 256; i++) pz[i] = 1'b0;
  endtask

  task automatic random_pause();
    for (int i = 0; i < 256; i++) pz[i] = (i >= 1 && i < 60) ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Runs one frame from an accepted start at edge 0; cycle k follows edge k-1.
  // Reference: every unpaused cycle from 2 on issues the next read, its pixel appears a cycle later.
  task automatic drive_frame(input logic s, input logic [AW-1:0] b, input int stop_pix);
    int c, bstart;
    sel = s;
    ny  = s ? 4 : 3;
    nn  = ny * (s ? 5 : 3);
    exp_vc.delete();
    c = 2;
    while (exp_vc.size() < nn) begin
      if (!pz[c]) exp_vc.push_back(c + 1);
      c++;
    end
    exp_last = exp_vc[nn-1];
    bstart   = exp_last + int'($urandom_range(0, 3));
    fall_c   = bstart + int'($urandom_range(2, 4));
    exp_done = fall_c + 1;
    sof_cyc.delete(); done_cyc.delete(); val_cyc.delete(); val_pix.delete();
    rd_addr.delete(); rd_x.delete(); rd_y.delete();
    overlap = 0;
    act_bad = 0;
    @(negedge clk);
    base_addr = b;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= exp_done + 3; k++) begin
      #1;
      // Extra starts in STREAM, WAIT_LO and the done cycle must all be ignored.
      start = (k == 4 || k == fall_c || k == exp_done);
      pause = pz[k];
      busy  = (k >= bstart && k < fall_c);
      @(negedge clk);
      if (o_sof) sof_cyc.push_back(k);
      if (o_valid) begin
        val_cyc.push_back(k);
        val_pix.push_back(o_pix);
      end
      if (o_rd) begin
        rd_addr.push_back(o_addr);
        rd_x.push_back(int'(o_x));
        rd_y.push_back(int'(o_y));
      end
      if (o_done) done_cyc.push_back(k);
      if (o_sof && o_valid) overlap++;
      if (o_active !== (k < exp_done)) act_bad++;
      if (stop_pix > 0 && val_cyc.size() == stop_pix) break;
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    pause = 1'b0;
    busy  = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs_a !== '0) $display("FAIL reset_a: got %h want 0", outs_a); else passes++;
    checks++; if (outs_b !== '0) $display("FAIL reset_b: got %h want 0", outs_b); else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (outs_a !== '0) $display("FAIL idle_a: got %h want 0", outs_a); else passes++;
    checks++; if (outs_b !== '0) $display("FAIL idle_b: got %h want 0", outs_b); else passes++;
  endtask

  task automatic test_basic();
    clear_pause();
    drive_frame(1'b0, 16'h0010, 0);
    checks++;
    if (sof_cyc.size() != 1 || sof_cyc[0] != 1)
      $display("FAIL basic_sof: got count %0d want 1 at cycle 1", sof_cyc.size());
    else passes++;
    checks++;
    if (val_cyc.size() != 9) $display("FAIL basic_count: got %0d want 9", val_cyc.size());
    else passes++;
    for (int i = 0; i < val_cyc.size() && i < 9; i++) begin
      checks++;
      if (val_pix[i] !== 8'(8'h10 + i) || val_cyc[i] != 3 + i)
        $display("FAIL basic_pix%0d: got %h@%0d want %h@%0d", i, val_pix[i], val_cyc[i],
                 8'(8'h10 + i), 3 + i);
      else passes++;
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != fall_c + 1)
      $display("FAIL basic_done: got count %0d want 1 at cycle %0d", done_cyc.size(), fall_c + 1);
    else passes++;
  endtask

  task automatic test_pause();
    clear_pause();
    pz[4] = 1'b1;
    pz[5] = 1'b1;
    drive_frame(1'b0, 16'h0010, 0);
    checks++;
    if (val_cyc.size() != 9) $display("FAIL pause_count: got %0d want 9", val_cyc.size());
    else passes++;
    for (int i = 0; i < val_cyc.size() && i < 9; i++) begin
      checks++;
      if (val_pix[i] !== 8'(8'h10 + i) || val_cyc[i] != exp_vc[i])
        $display("FAIL pause_pix%0d: got %h@%0d want %h@%0d", i, val_pix[i], val_cyc[i],
                 8'(8'h10 + i), exp_vc[i]);
      else passes++;
    end
    checks++;
    if (val_cyc.size() == 0 || val_cyc[val_cyc.size()-1] != 13)
      $display("FAIL pause_last: got %0d entries want last at cycle 13", val_cyc.size());
    else passes++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    clear_pause();
    drive_frame(1'b0, 16'hFFFE, 0);
    checks++;
    if (rd_addr.size() != 9) $display("FAIL wrap_reads: got %0d want 9", rd_addr.size());
    else passes++;
    for (int i = 0; i < rd_addr.size() && i < 9; i++) begin
      ea = 16'hFFFE + AW'(i);
      checks++;
      if (rd_addr[i] !== ea) $display("FAIL wrap_addr%0d: got %h want %h", i, rd_addr[i], ea);
      else passes++;
    end
    checks++;
    if (val_pix.size() != 9 || val_pix[2] !== 8'h00)
      $display("FAIL wrap_pix: got %0d pixels want 9 with third = 00", val_pix.size());
    else passes++;
  endtask

  task automatic test_ignored_start();
    random_pause();
    drive_frame(1'b0, AW'($urandom), 0);
    checks++;
    if (sof_cyc.size() != 1) $display("FAIL ign_sof: got %0d want 1", sof_cyc.size());
    else passes++;
    checks++;
    if (done_cyc.size() != 1) $display("FAIL ign_done: got %0d want 1", done_cyc.size());
    else passes++;
    checks++;
    if (act_bad != 0) $display("FAIL ign_active: got %0d bad cycles want 0", act_bad);
    else passes++;
    checks++;
    if (overlap != 0) $display("FAIL ign_overlap: got %0d want 0", overlap);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int sofs;
    clear_pause();
    drive_frame(1'b0, 16'h0020, 5);
    rst_n = 1'b0;
    #1;
    checks++; if (outs_a !== '0) $display("FAIL midrst_outs: got %h want 0", outs_a); else passes++;
    @(negedge clk) rst_n = 1'b1;
    sofs = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_a.sof || bus_a.done) sofs++;
    end
    checks++; if (sofs != 0) $display("FAIL midrst_quiet: got %0d want 0", sofs); else passes++;
    drive_frame(1'b0, 16'h0020, 0);
    checks++;
    if (sof_cyc.size() != 1 || sof_cyc[0] != 1)
      $display("FAIL midrst_sof: got count %0d want 1 at cycle 1", sof_cyc.size());
    else passes++;
    checks++;
    if (val_pix.size() != 9 || val_pix[0] !== 8'h20 || val_pix[8] !== 8'h28)
      $display("FAIL midrst_pix: got %0d pixels want 9 from 20 to 28", val_pix.size());
    else passes++;
  endtask

  task automatic test_random();
    logic [AW-1:0] b, ea;
    for (int f = 0; f < 6; f++) begin
      random_pause();
      b = AW'($urandom);
      drive_frame(f[0], b, 0);
      checks++;
      if (val_cyc.size() != nn || rd_addr.size() != nn)
        $display("FAIL rnd%0d_count: got %0d/%0d want %0d", f, val_cyc.size(), rd_addr.size(), nn);
      else passes++;
      for (int i = 0; i < nn && i < val_cyc.size() && i < rd_addr.size(); i++) begin
        ea = b + AW'(i);
        checks++;
        if (val_pix[i] !== ram_val(ea) || val_cyc[i] != exp_vc[i] || rd_addr[i] !== ea)
          $display("FAIL rnd%0d_pix%0d: got %h@%0d addr %h want %h@%0d addr %h", f, i,
                   val_pix[i], val_cyc[i], rd_addr[i], ram_val(ea), exp_vc[i], ea);
        else passes++;
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != exp_done || act_bad != 0)
        $display("FAIL rnd%0d_done: got count %0d act_bad %0d want 1 at %0d", f,
                 done_cyc.size(), act_bad, exp_done);
      else passes++;
    end
  endtask

  task automatic test_big();
    clear_pause();
    drive_frame(1'b1, AW'($urandom), 0);
    checks++;
    if (val_cyc.size() != 20 || val_cyc[19] != 22)
      $display("FAIL big_count: got %0d want 20 ending at cycle 22", val_cyc.size());
    else passes++;
    for (int i = 0; i < rd_x.size() && i < 20; i++) begin
      checks++;
      if (rd_x[i] != i / 4 || rd_y[i] != i % 4)
        $display("FAIL big_xy%0d: got x%0d y%0d want x%0d y%0d", i, rd_x[i], rd_y[i], i / 4, i % 4);
      else passes++;
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != fall_c + 1)
      $display("FAIL big_done: got count %0d want 1 at cycle %0d", done_cyc.size(), fall_c + 1);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_wrap();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_big();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
